// File: rtl/sevenseg_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sevenseg_scanner: 8-digit common-anode scanner with per-slot blanking and
// hex decode. Optional macro SEVENSEG_DIMMING_EN adds PWM brightness. Rev 1.0
// ---------------------------------------------------------------------------
module sevenseg_scanner #(
  parameter int DIGIT_PERIOD_CYCLES = 100000,
  parameter int BLANK_CYCLES        = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] display,
  input  logic [7:0]  digit_enable,
`ifdef SEVENSEG_DIMMING_EN
  input  logic [3:0]  brightness,
`endif
  output logic [7:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CNT_W = (DIGIT_PERIOD_CYCLES > 1) ? $clog2(DIGIT_PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT   = CNT_W'(DIGIT_PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       index_q, index_d;
  logic             en_q, en_d;
  logic [7:0]       anode_q, anode_d;
  logic [6:0]       cathode_q, cathode_d;
  logic             dp_q, dp_d;
  logic             frame_tick_q, frame_tick_d;
  logic             w_slot_end;
  logic             w_lit;
`ifdef SEVENSEG_DIMMING_EN
  logic [3:0]       pwm_q, pwm_d;
  logic [3:0]       bright_q, bright_d;
`endif

  // Segment patterns ordered g..a, active low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    index_d      = index_q;
    en_d         = en_q;
    cathode_d    = cathode_q;
    dp_d         = 1'b1;
    w_slot_end   = (cnt_q == C_LAST_CNT);
    frame_tick_d = w_slot_end && (index_q == 3'd7);

    if (w_slot_end) begin
      cnt_d   = '0;
      index_d = index_q + 3'd1;
    end

    case (state_q)
      S_BLANK: if (cnt_q == C_BLANK_LAST) state_d = S_SHOW;
      S_SHOW:  if (w_slot_end)            state_d = S_BLANK;
      default: state_d = S_BLANK;
    endcase

    // Snapshot one cycle before the anode turns on so the cathode has settled.
    if (cnt_d == C_BLANK_LAST) begin
      en_d      = digit_enable[index_d];
      cathode_d = hex_to_seg(display[{index_d, 2'b00} +: 4]);
    end

    w_lit = en_q;
`ifdef SEVENSEG_DIMMING_EN
    pwm_d    = pwm_q + 4'd1;
    bright_d = bright_q;
    if (cnt_d == C_BLANK_LAST) bright_d = brightness;
    w_lit = en_q && (pwm_d < bright_q);
`endif

    anode_d = 8'hFF;
    if (state_d == S_SHOW) anode_d[index_d] = ~w_lit;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_BLANK;
      cnt_q        <= '0;
      index_q      <= 3'd0;
      en_q         <= 1'b0;
      anode_q      <= 8'hFF;
      cathode_q    <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
`ifdef SEVENSEG_DIMMING_EN
      pwm_q        <= 4'd0;
      bright_q     <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      index_q      <= index_d;
      en_q         <= en_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
`ifdef SEVENSEG_DIMMING_EN
      pwm_q        <= pwm_d;
      bright_q     <= bright_d;
`endif
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
